// File: rtl/aes_pkg.sv
// aes_pkg: shared constants for the SPI host side of the AES encryption core.
package aes_pkg;

    localparam int BLK_W      = 128;
    localparam int SETTLE_DEF = 600;
    localparam int CNT_W      = 10;

    function automatic int key_width(input int nk);
        return 32 * nk;
    endfunction

    localparam int KEY_W_128 = key_width(4);
    localparam int KEY_W_192 = key_width(6);
    localparam int KEY_W_256 = key_width(8);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TX_DATA = 3'd1;
    localparam logic [2:0] S_TX_KEY  = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RX      = 3'd4;

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: right-shifting register with parallel load and serial-in at the MSB.
// Only the low PO_W bits are exposed; full_o rises once W shifts have been taken since load.
module spi_shift_reg
    import aes_pkg::*;
#(
    parameter int W    = BLK_W,
    parameter int PO_W = W
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [W-1:0]    load_val_i,
    input  logic            shift_i,
    input  logic            ser_i,
    output logic [PO_W-1:0] q_o,
    output logic            full_o
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          shift;

    // Shifts stop once full so the counter never wraps past W.
    assign full_o = cnt_q == CW'(W);
    assign shift  = shift_i && !full_o;
    assign q_o    = q_q[PO_W-1:0];

    always_comb begin
        q_d   = load_i ? load_val_i : shift ? {ser_i, q_q[W-1:1]} : q_q;
        cnt_d = load_i ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_spi_host.sv
// aes_spi_host: shifts plaintext then key to the AES core over CS/MOSI, holds CS low
// through the settle window, then collects the 128-bit ciphertext from MISO.
module aes_spi_host
    import aes_pkg::*;
#(
    parameter int KEY_W  = KEY_W_128,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [BLK_W-1:0] data_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BLK_W-1:0] data_o,
    output logic             cs_o,
    output logic             mosi_o,
    input  logic             miso_i
);

    localparam logic [CNT_W-1:0] BLK_C    = CNT_W'(BLK_W);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cs_q, cs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BLK_W-1:0] dout_q, dout_d;
    logic             load, tx_shift, rx_shift, tx_full, rx_full;
    logic [BLK_W-2:0] rx_q;

    // MOSI is the LSB of the TX register, so it is registered and zero once drained.
    spi_shift_reg #(.W(BLK_W + KEY_W), .PO_W(1)) u_tx (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (load),
        .load_val_i ({key_i, data_i}),
        .shift_i    (tx_shift),
        .ser_i      (1'b0),
        .q_o        (mosi_o),
        .full_o     (tx_full)
    );

    // Holds the first 127 ciphertext bits; the last one joins straight from MISO.
    spi_shift_reg #(.W(BLK_W - 1)) u_rx (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (load),
        .load_val_i ('0),
        .shift_i    (rx_shift),
        .ser_i      (miso_i),
        .q_o        (rx_q),
        .full_o     (rx_full)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = (state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
        cs_d     = cs_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dout_d   = dout_q;
        load     = 1'b0;
        tx_shift = 1'b0;
        rx_shift = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_TX_DATA;
                cnt_d   = CNT_W'(1);
                cs_d    = 1'b0;
                busy_d  = 1'b1;
                load    = 1'b1;
            end
            S_TX_DATA: begin
                tx_shift = 1'b1;
                state_d  = (cnt_q == BLK_C) ? S_TX_KEY : S_TX_DATA;
            end
            S_TX_KEY: begin
                tx_shift = 1'b1;
                state_d  = (cnt_q == SETTLE_C) ? S_RX : tx_full ? S_WAIT : S_TX_KEY;
            end
            S_WAIT: state_d = (cnt_q == SETTLE_C) ? S_RX : S_WAIT;
            S_RX: if (rx_full) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                cs_d    = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dout_d  = {miso_i, rx_q};
            end else begin
                rx_shift = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    assign cs_o   = cs_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign data_o = dout_q;

endmodule

// File: tb/tb_aes_spi_host.sv
// tb_aes_spi_host: directed bench driving two hosts (128- and 256-bit key) against a model SPI slave.
module tb_aes_spi_host;

    localparam int SETTLE = 600;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0, miso = 1'b1;
    logic [127:0] data = '0, resp = '0;
    logic [255:0] key = '0;
    logic [383:0] mosi_cap = '0;
    logic         busy_a, done_a, cs_a, mosi_a, busy_b, done_b, cs_b, mosi_b;
    logic [127:0] dout_a, dout_b;
    logic         busy_m, done_m, cs_m, mosi_m;
    logic [127:0] dout_m;
    int           n = 0, idx = 0, cs_run = 0, wait_bad = 0, extra = 0;
    int           errors = 0, checks = 0;

    assign busy_m = sel ? busy_b : busy_a;
    assign done_m = sel ? done_b : done_a;
    assign cs_m   = sel ? cs_b : cs_a;
    assign mosi_m = sel ? mosi_b : mosi_a;
    assign dout_m = sel ? dout_b : dout_a;

    always #5 clk = ~clk;

    aes_spi_host #(.KEY_W(128), .SETTLE(SETTLE)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start & ~sel), .data_i(data), .key_i(key[127:0]),
        .busy_o(busy_a), .done_o(done_a), .data_o(dout_a), .cs_o(cs_a), .mosi_o(mosi_a), .miso_i(miso)
    );

    aes_spi_host #(.KEY_W(256), .SETTLE(SETTLE)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start & sel), .data_i(data), .key_i(key),
        .busy_o(busy_b), .done_o(done_b), .data_o(dout_b), .cs_o(cs_b), .mosi_o(mosi_b), .miso_i(miso)
    );

    // Model slave: records MOSI, polices the quiet window, serves resp LSB-first during RX.
    always @(negedge clk) begin
        if (!cs_m) begin
            idx = n;
            n++;
            if (idx < 128 + (sel ? 256 : 128)) mosi_cap[idx] = mosi_m;
            else if (idx < SETTLE && mosi_m !== 1'b0) wait_bad++;
            miso = (idx >= SETTLE && idx < SETTLE + 128) ? resp[idx - SETTLE] : 1'b1;
        end else begin
            if (n != 0) cs_run = n;
            n = 0;
            miso = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input string tag);
        mosi_cap = '0;
        wait_bad = 0;
        cs_run   = 0;
        start    = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        chk({tag, "_acc_busy"}, 384'(busy_m), 384'(1));
        chk({tag, "_acc_cs"}, 384'(cs_m), 384'(0));
        chk({tag, "_acc_done"}, 384'(done_m), 384'(0));
    endtask

    task automatic finish_frame(input string tag, input int cyc0);
        int cyc = cyc0;
        while (!done_m && cyc < 2000) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        chk({tag, "_lat"}, 384'(cyc), 384'(SETTLE + 129));
        chk({tag, "_dout"}, 384'(dout_m), 384'(resp));
        chk({tag, "_busy"}, 384'(busy_m), 384'(0));
        chk({tag, "_cs"}, 384'(cs_m), 384'(1));
        @(negedge clk);
        #1;
        chk({tag, "_cs_run"}, 384'(cs_run), 384'(SETTLE + 128));
        chk({tag, "_mosi"}, mosi_cap, sel ? {key, data} : {128'b0, key[127:0], data});
        chk({tag, "_wait_mosi"}, 384'(wait_bad), 384'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cs", 384'({cs_a, cs_b}), 384'(2'b11));
        chk("rst_busy", 384'({busy_a, busy_b}), 384'(0));
        chk("rst_done", 384'({done_a, done_b}), 384'(0));
        chk("rst_mosi", 384'({mosi_a, mosi_b}), 384'(0));
        chk("rst_dout", 384'({dout_a, dout_b}), 384'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        data = 128'h00112233445566778899aabbccddeeff;
        key  = 256'h000102030405060708090a0b0c0d0e0f;
        resp = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        start_frame("abort");
        repeat (199) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_cs", 384'(cs_a), 384'(1));
        chk("abort_busy", 384'(busy_a), 384'(0));
        chk("abort_mosi", 384'(mosi_a), 384'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        start_frame("c1");
        finish_frame("c1", 1);
        @(posedge clk);
        #2;
        chk("c1_done_pulse", 384'(done_m), 384'(0));
        data = 128'hffeeddccbbaa99887766554433221100;
        key  = 256'h0f0e0d0c0b0a09080706050403020100;
        resp = 128'hdeadbeef0123456789abcdeffedcba98;
        mosi_cap = '0;
        wait_bad = 0;
        cs_run   = 0;
        start    = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        start = 1'b0;
        chk("held_busy", 384'(busy_m), 384'(1));
        repeat (100) @(posedge clk);
        #2;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        finish_frame("held", 104);
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #2;
            if (done_m || !cs_m) extra++;
        end
        chk("held_extra", 384'(extra), 384'(0));
        data = 128'h00112233445566778899aabbccddeeff;
        key  = 256'h000102030405060708090a0b0c0d0e0f;
        resp = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        start_frame("b2b1");
        finish_frame("b2b1", 1);
        data = 128'ha5a5a5a5c3c3c3c30123456789abcdef;
        key  = 256'h5a5a5a5a3c3c3c3cfedcba9876543210;
        resp = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        start_frame("b2b2");
        chk("b2b_hold", 384'(dout_m), 384'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
        finish_frame("b2b2", 1);
        @(posedge clk);
        #2;
        sel = 1'b1;
        @(posedge clk);
        #2;
        data = 128'h00112233445566778899aabbccddeeff;
        key  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        resp = 128'h8ea2b7ca516745bfeafc49904b496089;
        start_frame("c3");
        finish_frame("c3", 1);
        @(posedge clk);
        #2;
        chk("c3_done_pulse", 384'(done_m), 384'(0));
        chk("a_hold", 384'(dout_a), 384'(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
